// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter that serialises requests onto one shared ALU,
// returning each result through a held response handshake.

module alu #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       alu_control,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       alu_flags
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;

  // Subtract is a + ~b + 1; C is the raw carry-out, so 5-3 reports C=1.
  always_comb begin
    b_eff = alu_control[0] ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, alu_control[0]};
    case (alu_control)
      2'b10:   result = a & b;
      2'b11:   result = a | b;
      default: result = sum[WIDTH-1:0];
    endcase
    flag_n    = result[WIDTH-1];
    flag_z    = (result == '0);
    flag_c    = ~alu_control[1] & sum[WIDTH];
    flag_v    = ~alu_control[1] & ~(alu_control[0] ^ a[WIDTH-1] ^ b[WIDTH-1])
                & (a[WIDTH-1] ^ sum[WIDTH-1]);
    alu_flags = {flag_n, flag_z, flag_c, flag_v};
  end

endmodule

module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             gnt_id_q, gnt_id_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d;

  logic             winner;
  logic             any_valid;
  logic             granted_rsp_ready;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;

  alu #(.WIDTH(WIDTH)) u_alu (
    .a           (a_q),
    .b           (b_q),
    .alu_control (op_q),
    .result      (alu_result),
    .alu_flags   (alu_flags)
  );

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    gnt_id_d     = gnt_id_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;

    // Only a contested cycle consults the pointer; a lone requester always wins.
    any_valid         = req0_valid | req1_valid;
    winner            = (req0_valid & req1_valid) ? ~last_q : req1_valid;
    granted_rsp_ready = gnt_id_q ? rsp1_ready : rsp0_ready;

    case (state_q)
      IDLE: begin
        if (any_valid && !reset) begin
          req0_ready = ~winner;
          req1_ready = winner;
          gnt_id_d   = winner;
          last_d     = winner;
          op_d       = winner ? req1_op : req0_op;
          a_d        = winner ? req1_a  : req0_a;
          b_d        = winner ? req1_b  : req0_b;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_flags_d  = alu_flags;
        state_d      = RESP;
      end
      RESP: begin
        if (granted_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      gnt_id_q     <= 1'b0;
      op_q         <= 2'b00;
      a_q          <= '0;
      b_q          <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= 4'b0000;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      gnt_id_q     <= gnt_id_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  assign rsp0_valid = (state_q == RESP) && !gnt_id_q;
  assign rsp1_valid = (state_q == RESP) &&  gnt_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: single ops, fairness, back-pressure,
// mid-operation reset and withdrawn requests.

module tb_alu_arbiter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [1:0]       req0_op, req1_op;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             rsp0_valid, rsp1_valid;
  logic             rsp0_ready, rsp1_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [3:0]       rsp_flags;
  logic             busy;

  int vector_count = 0;
  int miss_count   = 0;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One uncontested transaction, consumed as soon as the response appears.
  task automatic applyStimulus(input int id, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_res,
                               input logic [3:0] exp_flags);
    if (id == 0) begin
      req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
    end else begin
      req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
    end
    #1;
    checkOutput($sformatf("req_ready_id%0d", id), 32'({req1_ready, req0_ready}), (id == 0) ? 32'h1 : 32'h2);
    tick;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    checkOutput("exec_state", 32'({busy, rsp1_valid, rsp0_valid, req1_ready, req0_ready}), 32'h10);
    tick;
    #1;
    checkOutput($sformatf("rsp_valid_id%0d", id), 32'({rsp1_valid, rsp0_valid}), (id == 0) ? 32'h1 : 32'h2);
    checkOutput($sformatf("rsp_result_id%0d", id), rsp_result, exp_res);
    checkOutput($sformatf("rsp_flags_id%0d", id), 32'(rsp_flags), 32'(exp_flags));
    if (id == 0) rsp0_ready = 1'b1;
    else         rsp1_ready = 1'b1;
    tick;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    #1;
    checkOutput("rsp_done", 32'({busy, rsp1_valid, rsp0_valid}), 32'h0);
  endtask

  // {req0_ready, req1_ready, rsp0_valid, rsp1_valid} per cycle under full contention
  logic [3:0] contend_exp [12] = '{4'b1000, 4'b0000, 4'b0010, 4'b0100, 4'b0000, 4'b0001,
                                   4'b1000, 4'b0000, 4'b0010, 4'b0100, 4'b0000, 4'b0001};

  initial begin
    reset      = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op    = 2'b00; req1_op   = 2'b00;
    req0_a     = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    tick;
    tick;
    req0_valid = 1'b1;
    #1;
    checkOutput("reset_outputs", 32'({busy, rsp1_valid, rsp0_valid, req1_ready, req0_ready}), 32'h0);
    checkOutput("reset_result", rsp_result, 32'h0);
    checkOutput("reset_flags", 32'(rsp_flags), 32'h0);
    reset      = 1'b0;
    req0_valid = 1'b0;

    applyStimulus(0, 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110);
    applyStimulus(1, 2'b01, 32'd5, 32'd3, 32'h0000_0002, 4'b0010);
    applyStimulus(1, 2'b10, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000);
    applyStimulus(1, 2'b11, 32'h8000_0000, 32'h0000_0001, 32'h8000_0001, 4'b1000);

    // Contention from reset with responses consumed immediately
    reset = 1'b1;
    tick;
    reset      = 1'b0;
    req0_op    = 2'b00; req0_a = 32'd1; req0_b = 32'd2; req0_valid = 1'b1;
    req1_op    = 2'b11; req1_a = 32'd4; req1_b = 32'd8; req1_valid = 1'b1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      checkOutput($sformatf("contend_c%0d", i), 32'({req0_ready, req1_ready, rsp0_valid, rsp1_valid}),
                  32'(contend_exp[i]));
      if (contend_exp[i][1]) checkOutput($sformatf("contend_res0_c%0d", i), rsp_result, 32'd3);
      if (contend_exp[i][0]) checkOutput($sformatf("contend_res1_c%0d", i), rsp_result, 32'd12);
      tick;
      #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Back-pressure on requester 0 while requester 1 waits
    req0_op = 2'b00; req0_a = 32'h7FFF_FFFF; req0_b = 32'h0000_0001; req0_valid = 1'b1;
    req1_op = 2'b01; req1_a = 32'd3; req1_b = 32'd5; req1_valid = 1'b1;
    rsp1_ready = 1'b1;
    #1;
    checkOutput("bp_grant", 32'({req1_ready, req0_ready}), 32'h1);
    tick;
    req0_valid = 1'b0;
    tick;
    #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp_hold_c%0d", i), 32'({req1_ready, rsp1_valid, rsp0_valid}), 32'h1);
      checkOutput($sformatf("bp_result_c%0d", i), rsp_result, 32'h8000_0000);
      checkOutput($sformatf("bp_flags_c%0d", i), 32'(rsp_flags), 32'(4'b1001));
      tick;
    end
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b0;
    tick;
    rsp0_ready = 1'b0;
    #1;
    checkOutput("bp_next_grant", 32'({busy, req1_ready, req0_ready}), 32'h2);
    tick;
    req1_valid = 1'b0;
    tick;
    #1;
    checkOutput("bp_rsp1_valid", 32'({rsp1_valid, rsp0_valid}), 32'h2);
    checkOutput("bp_rsp1_result", rsp_result, 32'hFFFF_FFFE);
    checkOutput("bp_rsp1_flags", 32'(rsp_flags), 32'(4'b1000));
    rsp1_ready = 1'b1;
    tick;
    rsp1_ready = 1'b0;

    // Reset during EXEC of a requester 0 add
    req0_op = 2'b00; req0_a = 32'd10; req0_b = 32'd20; req0_valid = 1'b1;
    #1;
    checkOutput("mid_grant", 32'({req1_ready, req0_ready}), 32'h1);
    tick;
    req0_valid = 1'b0;
    reset      = 1'b1;
    #1;
    checkOutput("mid_exec_busy", 32'(busy), 32'h1);
    tick;
    reset = 1'b0;
    #1;
    checkOutput("mid_outputs", 32'({busy, rsp1_valid, rsp0_valid, req1_ready, req0_ready}), 32'h0);
    checkOutput("mid_result", rsp_result, 32'h0);
    checkOutput("mid_flags", 32'(rsp_flags), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput($sformatf("mid_no_rsp_c%0d", i), 32'({busy, rsp0_valid}), 32'h0);
    end

    // Pointer back at reset value: requester 0 wins the simultaneous pair
    req0_op = 2'b00; req0_a = 32'd1; req0_b = 32'd1; req0_valid = 1'b1;
    req1_op = 2'b10; req1_a = 32'hFF; req1_b = 32'h0F; req1_valid = 1'b1;
    #1;
    checkOutput("post_reset_grant", 32'({req1_ready, req0_ready}), 32'h1);
    tick;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick;

    // Requester 1 pulses valid for one cycle during RESP
    req1_valid = 1'b1;
    #1;
    checkOutput("wd_ready", 32'({req1_ready, rsp1_valid, rsp0_valid}), 32'h1);
    checkOutput("wd_result", rsp_result, 32'd2);
    tick;
    req1_valid = 1'b0;
    #1;
    checkOutput("wd_still_resp", 32'({busy, rsp1_valid, rsp0_valid}), 32'h5);
    rsp0_ready = 1'b1;
    tick;
    rsp0_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("wd_idle_c%0d", i), 32'({busy, rsp1_valid, rsp0_valid, req1_ready}), 32'h0);
      tick;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter and sequencer that shares one instance of the existing `alu` datapath between two requesters, for example the fetch/address path and the execute path. Each requester presents an operation and its operands under a valid/ready handshake. The arbiter grants one request at a time, registers the operands, runs the ALU for one cycle, and returns the result and flags through a held response handshake to the granted requester. It sits between the requesters and the `alu` instance and is the only driver of the ALU inputs.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width. Must match the `alu` instance; only 32 is supported.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req0_valid`, `req1_valid` in 1: request present.
- `req0_ready`, `req1_ready` out 1: request accepted this cycle.
- `req0_op`, `req1_op` in 2: ALUControl encoding (00 add, 01 sub, 10 and, 11 or).
- `req0_a`, `req0_b`, `req1_a`, `req1_b` in WIDTH: operands.
- `rsp0_valid`, `rsp1_valid` out 1: response pending for that requester.
- `rsp0_ready`, `rsp1_ready` in 1: requester consumes the response.
- `rsp_result` out WIDTH: shared result bus; meaningful only while some `rspN_valid` is high.
- `rsp_flags` out 4: shared flags {N,Z,C,V} (bit3..bit0), exactly as produced by `alu`.
- `busy` out 1: high in EXEC and RESP.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: `rsp0_valid` = `rsp1_valid` = 0, `rsp_result` = 0, `rsp_flags` = 0, `busy` = 0, `req0_ready` = `req1_ready` = 0 while `reset` is high.
- Round-robin pointer `last`: resets to 1, so requester 0 has priority first.
- IDLE:
  - Winner = the only valid requester, or, if both are valid, the one that is not `last`.
  - `reqN_ready` is combinational: it is 1 only for the winner, only in IDLE, and only when `reset` is 0.
  - On the handshake edge, register op, a, b and the winner id, set `last` to the winner, and go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC: the ALU sees only the registered op/a/b. At the end of the cycle, capture the ALU Result into `rsp_result` and ALUFlags into `rsp_flags`, then go to RESP.
- RESP:
  - `rspN_valid` is 1 only for the granted id.
  - `rsp_result` and `rsp_flags` are held stable until the handshake.
  - On `rspN_ready` for the granted id, clear valid and go to IDLE.
  - `rsp_ready` from the non-granted requester is ignored.
- No request is accepted outside IDLE; `reqN_ready` stays 0 in EXEC and RESP. Requesters must hold valid and operands until ready.
- A request whose valid drops before it is granted has no effect.
- Flags are passed through unmodified from `alu`. For and/or, C and V are 0.
- Reset during EXEC or RESP abandons the transaction: no response is produced, and the state returns to the reset values on the next edge.

## Timing
- Request accepted on edge T (IDLE cycle with valid and ready both high).
- EXEC occupies cycle T+1.
- `rsp_valid` is high from cycle T+2 and remains high until the `rsp_ready` edge.
- Minimum spacing between accepts is 3 cycles; the IDLE cycle after the response is mandatory.
- Response taken on edge R: the next accept can occur no earlier than the edge at R+1.
- With both requesters continuously valid and both responses consumed immediately, grants alternate 0,1,0,1,…

## Test plan
- Reset then single request: reset high 2 cycles then low; req0 add, a=0xFFFFFFFF, b=0x00000001 -> `req0_ready` in the first IDLE cycle, `rsp0_valid` 2 cycles after accept, `rsp_result`=0x00000000, `rsp_flags`=4'b0110, `rsp1_valid`=0 throughout.
- Subtract and logical ops on req1:
  - sub 5-3 -> result 0x00000002, flags 4'b0010.
  - and 0xF0F0F0F0 & 0x0FF00FF0 -> result 0x00F000F0, flags 4'b0000.
  - or 0x80000000 | 0x00000001 -> result 0x80000001, flags 4'b1000.
- Contention and fairness: both requesters valid from reset, responses consumed immediately -> grant order 0,1,0,1. `req1_ready` is never high in the same cycle as `req0_ready`. Each accept is exactly 3 cycles after the previous one.
- Response back-pressure: hold `rsp0_ready`=0 for 5 cycles in RESP -> `rsp0_valid`, `rsp_result` and `rsp_flags` stay stable. `req1_valid` is high throughout but `req1_ready` stays 0. `rsp1_ready`=1 during this time does not clear the response. After `rsp0_ready`, req1 is accepted on the next IDLE cycle.
- Reset mid-operation: assert reset in EXEC of a req0 add -> no `rsp0_valid` ever appears for it. All outputs return to 0. The next simultaneous request pair grants requester 0 first.
- Request withdrawn: `req1_valid` pulses for 1 cycle while the arbiter is in RESP -> no accept and no response for it. `busy` returns to 0 after the current response is consumed.
